// File: rtl/lcd_win_pkg.sv
// Shared opcode and FSM state definitions for the lcd_win_ctrl image window controller.
// Also hosts small opcode classification helpers used by the controller.
package lcd_win_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OpWrite  = 4'h0;
    localparam opcode_t OpUp     = 4'h1;
    localparam opcode_t OpDown   = 4'h2;
    localparam opcode_t OpLeft   = 4'h3;
    localparam opcode_t OpRight  = 4'h4;
    localparam opcode_t OpMax    = 4'h5;
    localparam opcode_t OpMin    = 4'h6;
    localparam opcode_t OpAvg    = 4'h7;
    localparam opcode_t OpCcw    = 4'h8;
    localparam opcode_t OpCw     = 4'h9;
    localparam opcode_t OpMirX   = 4'hA;
    localparam opcode_t OpMirY   = 4'hB;
    localparam opcode_t OpLoad   = 4'hC;
    localparam opcode_t OpCenter = 4'hD;

    typedef logic [1:0] state_t;

    localparam state_t StLoad  = 2'd0;
    localparam state_t StIdle  = 2'd1;
    localparam state_t StExec  = 2'd2;
    localparam state_t StWrite = 2'd3;

    // Opcodes E and F are reserved and never accepted.
    function automatic logic is_valid_op(opcode_t op);
        return op <= OpCenter;
    endfunction

    // Opcodes whose result rewrites the four window pixels.
    function automatic logic is_alu_op(opcode_t op);
        return (op >= OpMax) && (op <= OpMirY);
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: max/min/average fills and rotations/mirrors.
// Build option LCD_WIN_AVG_ROUND_EN makes AVG round half up instead of flooring.
module lcd_win_alu
    import lcd_win_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [3:0]       op_i,
    input  logic [PIX_W-1:0] tl_i,
    input  logic [PIX_W-1:0] tr_i,
    input  logic [PIX_W-1:0] bl_i,
    input  logic [PIX_W-1:0] br_i,
    output logic [PIX_W-1:0] tl_o,
    output logic [PIX_W-1:0] tr_o,
    output logic [PIX_W-1:0] bl_o,
    output logic [PIX_W-1:0] br_o
);

    localparam int unsigned SW = PIX_W + 2;

    logic [PIX_W-1:0] max_top;
    logic [PIX_W-1:0] max_bot;
    logic [PIX_W-1:0] max_all;
    logic [PIX_W-1:0] min_top;
    logic [PIX_W-1:0] min_bot;
    logic [PIX_W-1:0] min_all;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_adj;
    logic [PIX_W-1:0] avg;

    always_comb begin
        max_top = (tl_i > tr_i) ? tl_i : tr_i;
        max_bot = (bl_i > br_i) ? bl_i : br_i;
        max_all = (max_top > max_bot) ? max_top : max_bot;
        min_top = (tl_i < tr_i) ? tl_i : tr_i;
        min_bot = (bl_i < br_i) ? bl_i : br_i;
        min_all = (min_top < min_bot) ? min_top : min_bot;

        sum = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
`ifdef LCD_WIN_AVG_ROUND_EN
        // Cannot overflow: 4*(2^PIX_W-1)+2 < 2^SW.
        sum_adj = sum + SW'(2);
`else
        sum_adj = sum;
`endif
        avg = sum_adj[SW-1:2];
    end

    always_comb begin
        tl_o = tl_i;
        tr_o = tr_i;
        bl_o = bl_i;
        br_o = br_i;
        case (op_i)
            OpMax: begin
                tl_o = max_all;
                tr_o = max_all;
                bl_o = max_all;
                br_o = max_all;
            end
            OpMin: begin
                tl_o = min_all;
                tr_o = min_all;
                bl_o = min_all;
                br_o = min_all;
            end
            OpAvg: begin
                tl_o = avg;
                tr_o = avg;
                bl_o = avg;
                br_o = avg;
            end
            OpCw: begin
                tl_o = bl_i;
                bl_o = br_i;
                br_o = tr_i;
                tr_o = tl_i;
            end
            OpCcw: begin
                tl_o = tr_i;
                tr_o = br_i;
                br_o = bl_i;
                bl_o = tl_i;
            end
            OpMirX: begin
                tl_o = bl_i;
                tr_o = br_i;
                bl_o = tl_i;
                br_o = tr_i;
            end
            OpMirY: begin
                tl_o = tr_i;
                tr_o = tl_i;
                bl_o = br_i;
                br_o = bl_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// Image window controller: loads an image from IROM, edits a movable 2x2 window, streams to IRAM.
// Build option LCD_WIN_AVG_ROUND_EN (in lcd_win_alu) selects rounded averaging.
module lcd_win_ctrl
    import lcd_win_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned PIX_W = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        cmd,
    input  logic                              cmd_valid,
    input  logic [PIX_W-1:0]                  IROM_Q,
    output logic                              IROM_rd,
    output logic [$clog2(IMG_W*IMG_H)-1:0]    IROM_A,
    output logic                              IRAM_valid,
    output logic [PIX_W-1:0]                  IRAM_D,
    output logic [$clog2(IMG_W*IMG_H)-1:0]    IRAM_A,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    state_t           state_q, state_d;
    opcode_t          op_q, op_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             rom_rd_q, rom_rd_d;
    logic [AW-1:0]    rom_a_q, rom_a_d;
    logic             ram_valid_q, ram_valid_d;
    logic [AW-1:0]    ram_a_q, ram_a_d;
    logic [PIX_W-1:0] ram_d_q, ram_d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] buf_q [N];
    logic [PIX_W-1:0] buf_d [N];

    logic             accept;
    logic [XW-1:0]    xm1;
    logic [YW-1:0]    ym1;
    logic [AW-1:0]    idx_tl, idx_tr, idx_bl, idx_br;
    logic [AW-1:0]    ram_a_nxt;
    logic [PIX_W-1:0] alu_tl, alu_tr, alu_bl, alu_br;

    // Power-of-two dimensions let the linear index be a plain {row, col} concatenation.
    always_comb begin
        xm1       = x_q - XW'(1);
        ym1       = y_q - YW'(1);
        idx_tl    = {ym1, xm1};
        idx_tr    = {ym1, x_q};
        idx_bl    = {y_q, xm1};
        idx_br    = {y_q, x_q};
        ram_a_nxt = ram_a_q + AW'(1);
        accept    = cmd_valid && !busy_q && is_valid_op(cmd);
    end

    lcd_win_alu #(
        .PIX_W (PIX_W)
    ) u_alu (
        .op_i (op_q),
        .tl_i (buf_q[idx_tl]),
        .tr_i (buf_q[idx_tr]),
        .bl_i (buf_q[idx_bl]),
        .br_i (buf_q[idx_br]),
        .tl_o (alu_tl),
        .tr_o (alu_tr),
        .bl_o (alu_bl),
        .br_o (alu_br)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        rom_rd_d    = rom_rd_q;
        rom_a_d     = rom_a_q;
        ram_valid_d = ram_valid_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        busy_d      = busy_q;
        done_d      = done_q;
        buf_d       = buf_q;

        case (state_q)
            StLoad: begin
                if (rom_rd_q) begin
                    buf_d[rom_a_q] = IROM_Q;
                    if (rom_a_q == AW'(N - 1)) begin
                        rom_rd_d = 1'b0;
                        rom_a_d  = '0;
                        busy_d   = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        rom_a_d = rom_a_q + AW'(1);
                    end
                end else begin
                    // First cycle out of reset: start the sweep at address 0.
                    rom_rd_d = 1'b1;
                    rom_a_d  = '0;
                end
            end

            StIdle: begin
                if (accept) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    op_d   = cmd;
                    case (cmd)
                        OpWrite: begin
                            state_d     = StWrite;
                            ram_valid_d = 1'b1;
                            ram_a_d     = '0;
                            ram_d_d     = buf_q[0];
                        end
                        OpLoad: begin
                            state_d  = StLoad;
                            rom_rd_d = 1'b1;
                            rom_a_d  = '0;
                        end
                        default: state_d = StExec;
                    endcase
                end
            end

            StExec: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                case (op_q)
                    OpUp:     if (y_q > YW'(1)) y_d = y_q - YW'(1);
                    OpDown:   if (y_q < YW'(IMG_H - 1)) y_d = y_q + YW'(1);
                    OpLeft:   if (x_q > XW'(1)) x_d = x_q - XW'(1);
                    OpRight:  if (x_q < XW'(IMG_W - 1)) x_d = x_q + XW'(1);
                    OpCenter: begin
                        x_d = XW'(IMG_W / 2);
                        y_d = YW'(IMG_H / 2);
                    end
                    default: begin
                        if (is_alu_op(op_q)) begin
                            buf_d[idx_tl] = alu_tl;
                            buf_d[idx_tr] = alu_tr;
                            buf_d[idx_bl] = alu_bl;
                            buf_d[idx_br] = alu_br;
                        end
                    end
                endcase
            end

            StWrite: begin
                if (ram_a_q == AW'(N - 1)) begin
                    ram_valid_d = 1'b0;
                    ram_a_d     = '0;
                    ram_d_d     = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end else begin
                    ram_a_d = ram_a_nxt;
                    ram_d_d = buf_q[ram_a_nxt];
                end
            end

            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StLoad;
            op_q        <= OpWrite;
            x_q         <= XW'(IMG_W / 2);
            y_q         <= YW'(IMG_H / 2);
            rom_rd_q    <= 1'b0;
            rom_a_q     <= '0;
            ram_valid_q <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rom_rd_q    <= rom_rd_d;
            rom_a_q     <= rom_a_d;
            ram_valid_q <= ram_valid_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Pixel storage carries no reset; contents are rebuilt by the load sweep.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign IROM_rd    = rom_rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = ram_valid_q;
    assign IRAM_A     = ram_a_q;
    assign IRAM_D     = ram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl (8x8x8, ROM pixel i = i): vector table plus reset/write corner cases.
module tb_lcd_win_ctrl;

    localparam logic [3:0] OP_WRITE  = 4'h0;
    localparam logic [3:0] OP_UP     = 4'h1;
    localparam logic [3:0] OP_DOWN   = 4'h2;
    localparam logic [3:0] OP_LEFT   = 4'h3;
    localparam logic [3:0] OP_RIGHT  = 4'h4;
    localparam logic [3:0] OP_MAX    = 4'h5;
    localparam logic [3:0] OP_MIN    = 4'h6;
    localparam logic [3:0] OP_AVG    = 4'h7;
    localparam logic [3:0] OP_CCW    = 4'h8;
    localparam logic [3:0] OP_CW     = 4'h9;
    localparam logic [3:0] OP_MIRX   = 4'hA;
    localparam logic [3:0] OP_MIRY   = 4'hB;
    localparam logic [3:0] OP_LOAD   = 4'hC;
    localparam logic [3:0] OP_CENTER = 4'hD;

`ifdef LCD_WIN_AVG_ROUND_EN
    localparam int AVG_EXP = 29;
`else
    localparam int AVG_EXP = 28;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] irom_q;
    logic       irom_rd;
    logic [5:0] irom_a;
    logic       iram_valid;
    logic [7:0] iram_d;
    logic [5:0] iram_a;
    logic       busy;
    logic       done;

    lcd_win_ctrl #(
        .IMG_W (8),
        .IMG_H (8),
        .PIX_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_Q     (irom_q),
        .IROM_rd    (irom_rd),
        .IROM_A     (irom_a),
        .IRAM_valid (iram_valid),
        .IRAM_D     (iram_d),
        .IRAM_A     (iram_a),
        .busy       (busy),
        .done       (done)
    );

    assign irom_q = {2'b00, irom_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      op;
        logic [2:0]      n;
        logic [3:0][5:0] a;
        logic [3:0][7:0] v;
    } vec_t;

    vec_t vt [$];
    int   exp_img [64];
    int   cap [64];
    int   total;
    int   bad;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] op, input int n, input int a0, input int a1,
                       input int a2, input int a3, input int v0, input int v1,
                       input int v2, input int v3);
        vec_t e;
        e.op   = op;
        e.n    = 3'(n);
        e.a[0] = 6'(a0);
        e.a[1] = 6'(a1);
        e.a[2] = 6'(a2);
        e.a[3] = 6'(a3);
        e.v[0] = 8'(v0);
        e.v[1] = 8'(v1);
        e.v[2] = 8'(v2);
        e.v[3] = 8'(v3);
        vt.push_back(e);
    endtask

    task automatic add_rep(input logic [3:0] op, input int cnt);
        for (int i = 0; i < cnt; i++) add(op, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_expected();
        for (int i = 0; i < 64; i++) exp_img[i] = i;
    endtask

    // Expects IROM_rd already high with address 0.
    task automatic wait_load();
        int n;
        int bad_a;
        n = 0;
        bad_a = 0;
        for (int c = 0; c < 200; c++) begin
            if (!irom_rd) break;
            if (int'(irom_a) != n) bad_a++;
            n++;
            tick();
        end
        check("load_count", n, 64);
        check("load_seq", bad_a, 0);
        check("load_busy_end", int'(busy), 0);
        check("load_a_end", int'(irom_a), 0);
    endtask

    task automatic run_write(input bit inject);
        int nv;
        int seq_bad;
        int img_bad;
        nv = 0;
        seq_bad = 0;
        for (int i = 0; i < 64; i++) cap[i] = -1;
        cmd = OP_WRITE;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr_busy", int'(busy), 1);
        check("wr_done_clr", int'(done), 0);
        for (int c = 0; c < 100; c++) begin
            if (!iram_valid) break;
            if (int'(iram_a) != nv) seq_bad++;
            cap[iram_a] = int'(iram_d);
            nv++;
            if (inject && nv >= 10 && nv < 20) begin
                cmd = OP_MAX;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("wr_count", nv, 64);
        check("wr_seq", seq_bad, 0);
        check("wr_done", int'(done), 1);
        check("wr_busy_end", int'(busy), 0);
        check("wr_addr_end", int'(iram_a), 0);
        img_bad = 0;
        for (int i = 0; i < 64; i++) if (cap[i] != exp_img[i]) img_bad++;
        check("wr_image", img_bad, 0);
    endtask

    task automatic run_vec(input int k, input vec_t e);
        cmd = e.op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check($sformatf("v%0d_busy", k), int'(busy), 1);
        check($sformatf("v%0d_done", k), int'(done), 0);
        if (e.op == OP_LOAD) begin
            reset_expected();
            check($sformatf("v%0d_rd", k), int'(irom_rd), 1);
            wait_load();
        end else begin
            tick();
            check($sformatf("v%0d_exec1", k), int'(busy), 0);
        end
        for (int j = 0; j < int'(e.n); j++) exp_img[e.a[j]] = int'(e.v[j]);
        if (e.n != 0) begin
            run_write(1'b0);
            for (int j = 0; j < int'(e.n); j++)
                check($sformatf("v%0d_pix%0d", k, e.a[j]), cap[e.a[j]], int'(e.v[j]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        cmd = 4'h0;
        cmd_valid = 1'b0;
        reset_expected();

        // Window starts at (4,4): TL=27 TR=28 BL=35 BR=36.
        add(OP_CW,   4, 27, 28, 35, 36, 35, 27, 36, 28);
        add(OP_CCW,  4, 27, 28, 35, 36, 27, 28, 35, 36);
        add(OP_MIRX, 4, 27, 28, 35, 36, 35, 36, 27, 28);
        add(OP_MIRX, 4, 27, 28, 35, 36, 27, 28, 35, 36);
        add(OP_MIRY, 4, 27, 28, 35, 36, 28, 27, 36, 35);
        add(OP_MIRY, 4, 27, 28, 35, 36, 27, 28, 35, 36);
        add(OP_MAX,  4, 27, 28, 35, 36, 36, 36, 36, 36);
        add_rep(OP_LEFT, 5);
        add(OP_AVG,  4, 24, 25, 32, 33, AVG_EXP, AVG_EXP, AVG_EXP, AVG_EXP);
        add_rep(OP_RIGHT, 10);
        add(OP_MIN,  4, 30, 31, 38, 39, 30, 30, 30, 30);
        add_rep(OP_UP, 5);
        add(OP_MAX,  4, 6, 7, 14, 15, 15, 15, 15, 15);
        add_rep(OP_DOWN, 10);
        add(OP_MIN,  4, 54, 55, 62, 63, 54, 54, 54, 54);
        add_rep(OP_CENTER, 1);
        add_rep(OP_LEFT, 1);
        // At (3,4): 26, 27(=36), 34, 35(=36).
        add(OP_CW,   4, 26, 27, 34, 35, 34, 26, 36, 36);
        add_rep(OP_LOAD, 1);
        add(OP_MAX,  4, 26, 27, 34, 35, 35, 35, 35, 35);

        tick();
        tick();
        check("rst_rd", int'(irom_rd), 0);
        check("rst_rom_a", int'(irom_a), 0);
        check("rst_valid", int'(iram_valid), 0);
        check("rst_ram_d", int'(iram_d), 0);
        check("rst_ram_a", int'(iram_a), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);

        reset = 1'b1;
        tick();
        check("rel_rd", int'(irom_rd), 1);
        check("rel_a", int'(irom_a), 0);
        wait_load();
        check("idle_done", int'(done), 0);

        run_write(1'b0);
        tick();
        tick();
        check("done_hold", int'(done), 1);

        foreach (vt[k]) run_vec(k, vt[k]);

        // Reserved opcodes: no busy, done kept.
        cmd = 4'hE;
        cmd_valid = 1'b1;
        tick();
        check("opE_busy", int'(busy), 0);
        check("opE_done", int'(done), 1);
        cmd = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("opF_busy", int'(busy), 0);
        tick();
        check("opF_busy2", int'(busy), 0);

        // MAX presented during the write stream must be ignored.
        run_write(1'b1);
        tick();
        check("inject_idle", int'(busy), 0);
        run_write(1'b0);

        // Reset in the middle of a load restarts the sweep and recentres the window.
        reset = 1'b0;
        tick();
        check("rst2_rd", int'(irom_rd), 0);
        check("rst2_done", int'(done), 0);
        reset = 1'b1;
        tick();
        check("rel2_rd", int'(irom_rd), 1);
        for (int i = 0; i < 30; i++) tick();
        check("mid_load_a", int'(irom_a), 30);
        reset = 1'b0;
        tick();
        check("rst3_rd", int'(irom_rd), 0);
        check("rst3_a", int'(irom_a), 0);
        check("rst3_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check("rel3_rd", int'(irom_rd), 1);
        check("rel3_a", int'(irom_a), 0);
        wait_load();
        reset_expected();
        run_vec(900, '{op: OP_MAX, n: 3'd4, a: {6'd36, 6'd35, 6'd28, 6'd27},
                       v: {8'd36, 8'd36, 8'd36, 8'd36}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
